// File: rtl/soi_obs_pkg.sv
// soi_obs_pkg: shared types for the signal-of-interest observer.
//   obs_state_t : capture FSM states (OFF / PRIME / RUN)
//   obs_rec_t   : capture record {value, ts, gap}; fields are sized for the
//                 widest supported configuration (WIDTH, TS_W <= 64) and the
//                 observer zero-extends into them
//   sat_inc16   : saturating 16-bit increment used by the drop counter
package soi_obs_pkg;

    localparam int REC_VALUE_W = 64;
    localparam int REC_TS_W    = 64;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } obs_state_t;

    typedef struct packed {
        logic [REC_VALUE_W-1:0] value;
        logic [REC_TS_W-1:0]    ts;
        logic                   gap;
    } obs_rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/soi_obs_fifo.sv
// soi_obs_fifo: synchronous record FIFO, registered storage, no read-through.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i; accepted when not full, or full with a pop
//   wdata_i   : record to store
//   pop_i     : remove the head record (ignored when empty)
//   rdata_o   : head record (valid while !empty_o)
//   full_o    : DEPTH entries stored
//   empty_o   : no entries stored
//   level_o   : occupancy 0..DEPTH
module soi_obs_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_o = wptr_q - rptr_q;
    assign full_o  = level_o == (AW+1)'(DEPTH);
    assign empty_o = level_o == '0;
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO frees its head slot on a pop, so the write can land there.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/soi_observer.sv
// soi_observer: records changes of a signal of interest with cycle timestamps
// into a FIFO and presents them to a host bridge through a valid/ready stage.
//   clk, rst      : clock, synchronous active-high reset
//   en            : observation enable; first enabled edge primes a capture
//   soi           : observed signal
//   force_sample  : capture soi even when unchanged
//   out_valid/out_ready : output handshake
//   out_value, out_ts, out_gap : presented record
//   drop_count    : saturating count of records lost to a full FIFO
//   level         : FIFO occupancy, output stage excluded
module soi_observer
    import soi_obs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int TS_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         soi,
    input  logic                     force_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_value,
    output logic [TS_W-1:0]          out_ts,
    output logic                     out_gap,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int RW = WIDTH + TS_W + 1;

    obs_state_t       state_q, state_d, mode;
    logic [TS_W-1:0]  ts_q;
    logic [WIDTH-1:0] last_q, last_d;
    logic             pend_q, pend_d;
    logic [15:0]      drop_q, drop_d;
    obs_rec_t         out_q, out_d;
    logic             out_valid_q, out_valid_d;
    obs_rec_t         cap_rec;
    logic             capture;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [RW-1:0]    fifo_rdata;
    logic [RW-1:0]    fifo_wdata;
    logic             unused_rec_hi;

    // Upper record bits beyond WIDTH/TS_W are always zero and never read.
    assign unused_rec_hi = ^{cap_rec, out_q};

    always_comb begin
        // The edge where en first appears is the PRIME edge; the registered
        // state then records PRIME and moves on to RUN.
        mode = !en ? S_OFF : (state_q == S_OFF ? S_PRIME : S_RUN);
        capture = (mode == S_PRIME) || (mode == S_RUN && (soi != last_q || force_sample));
        pop = !fifo_empty && (!out_valid_q || out_ready);
        accept = capture && (!fifo_full || pop);
        cap_rec = '0;
        cap_rec.value = REC_VALUE_W'(soi);
        cap_rec.ts = REC_TS_W'(ts_q);
        cap_rec.gap = pend_q;
        fifo_wdata = {cap_rec.value[WIDTH-1:0], cap_rec.ts[TS_W-1:0], cap_rec.gap};
        state_d = mode;
        // A dropped capture still counts as the last seen value.
        last_d = capture ? soi : last_q;
        pend_d = accept ? 1'b0 : (capture ? 1'b1 : pend_q);
        drop_d = (capture && !accept) ? sat_inc16(drop_q) : drop_q;
        out_valid_d = pop || (out_valid_q && !out_ready);
        out_d = out_q;
        if (pop) begin
            out_d = '0;
            out_d.value = REC_VALUE_W'(fifo_rdata[RW-1:TS_W+1]);
            out_d.ts = REC_TS_W'(fifo_rdata[TS_W:1]);
            out_d.gap = fifo_rdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OFF;
            ts_q        <= '0;
            last_q      <= '0;
            pend_q      <= 1'b0;
            drop_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_q + TS_W'(1);
            last_q      <= last_d;
            pend_q      <= pend_d;
            drop_q      <= drop_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    soi_obs_fifo #(
        .DW    (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (capture),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign out_valid  = out_valid_q;
    assign out_value  = out_q.value[WIDTH-1:0];
    assign out_ts     = out_q.ts[TS_W-1:0];
    assign out_gap    = out_q.gap;
    assign drop_count = drop_q;

endmodule

// File: doc/soi_observer.md
SOI_OBSERVER -- requirements
Module: soi_observer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the observed signal.
REQ-002 SHALL have parameter DEPTH, default 8: record FIFO depth; power of two, at least 2.
REQ-003 SHALL have parameter TS_W, default 32: timestamp width.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port en  input  1  observation enable.
REQ-007 SHALL have port soi  input  WIDTH  signal of interest.
REQ-008 SHALL have port force_sample  input  1  capture the current soi even if it is unchanged.
REQ-009 SHALL have port out_valid  output  1  a record is presented to the host bridge.
REQ-010 SHALL have port out_ready  input  1  the host bridge accepts the record.
REQ-011 SHALL have port out_value  output  WIDTH  recorded soi value.
REQ-012 SHALL have port out_ts  output  TS_W  cycle timestamp of the capture.
REQ-013 SHALL have port out_gap  output  1  one or more records were dropped before this record.
REQ-014 SHALL have port drop_count  output  16  saturating count of dropped records.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy, excluding the output stage.

Function
REQ-016 SHALL keep a free-running timestamp counter that increments every cycle after reset and wraps modulo 2^TS_W.
REQ-017 SHALL run a three-state FSM:
- OFF: en=0; no captures.
- PRIME: on the first edge with en=1, unconditionally capture soi, then go to RUN.
- RUN: capture when soi != last_captured or force_sample=1.
- Any state goes to OFF when en=0.
REQ-018 SHALL create a capture record of {soi, timestamp at that edge, gap}, update last_captured, and push the record in the same edge.
REQ-019 SHALL give a record captured at edge N into an empty FIFO and empty output stage out_valid=1 after edge N+1, with out_ts equal to the timestamp at edge N.
REQ-020 SHALL transfer a record on an edge where out_valid and out_ready are both 1.
REQ-021 SHALL hold out_value, out_ts and out_gap stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain one record per cycle when out_ready is held at 1.
REQ-023 SHALL drop a capture when the FIFO is full and no pop occurs on the same edge, and SHALL then increment drop_count, saturating at 16'hFFFF.
REQ-024 SHALL still update last_captured when a capture is dropped.
REQ-025 SHALL set a pending-gap flag on a drop, attach it to the next accepted record as gap=1, and then clear it.
REQ-026 SHALL accept the push when the FIFO is full and a pop to the output stage occurs on the same edge; level is then unchanged.
REQ-027 SHALL let the FIFO and output stage keep draining while en=0, and SHALL retain the pending-gap flag.

Reset
REQ-028 SHALL apply reset synchronously with priority over every other input.
REQ-029 SHALL set on reset: FSM=OFF, timestamp=0, out_valid=0, out_value=0, out_ts=0, out_gap=0, drop_count=0, level=0, pending-gap=0, last_captured=0.
REQ-030 SHALL discard any record in flight or queued when reset is asserted mid-operation; the first capture after reset goes through PRIME.

Structure
REQ-031 SHALL place the record struct type (value, ts, gap) and the FSM state enum in the package soi_obs_pkg.
REQ-032 SHALL implement storage in the sub-module soi_obs_fifo: a synchronous FIFO with push, pop, full, empty and level outputs and no same-cycle read-through.
REQ-033 SHALL have the top level contain the FSM, change detection, timestamp counter, drop and gap logic, and the output register stage.

Verification
REQ-034 SHALL cover enable priming: rst, then en=1 with soi=5 held -> exactly one record {5, ts of the PRIME edge, gap=0}.
REQ-035 SHALL cover toggle streaming: out_ready=1 and soi toggling 0/1 every cycle -> one record per cycle with consecutive out_ts values and level staying at most 1.
REQ-036 SHALL cover overflow: DEPTH=8, out_ready=0, then 12 changes -> 9 records held (8 in FIFO plus output stage), drop_count=3, next accepted record has gap=1.
REQ-037 SHALL cover forced sampling: soi held constant at 7 and force_sample pulsed 2 cycles -> two records with value 7 and timestamps 1 apart.
REQ-038 SHALL cover back-pressure and mid-operation reset: out_ready low for 5 cycles -> out_* stable throughout; then rst with level=4 -> all outputs at reset values on the next cycle.
REQ-039 SHALL cover timestamp wrap: TS_W=4 over 20 cycles of changes -> out_ts wraps 15 to 0 with no missing records.
